// File: rtl/fifo_rr_drain_sched.sv
// Round-robin drain of NUM_Q source FIFOs into one registered valid/ready stream.
// One queue is granted at a time for a burst of up to BURST_LEN words.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrate: pick next non-empty queue after rr_last (no pop)
// S_GRANT | pop granted queue while output slot is free, up to burst cap
module fifo_rr_drain_sched #(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int QID_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_Q-1:0]            q_empty,
  input  logic [NUM_Q*DATA_WIDTH-1:0] q_data,
  output logic [NUM_Q-1:0]            q_re_en,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [QID_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [QID_W-1:0]            grant_id
);

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);

  logic [0:0]            state;
  logic [QID_W-1:0]      rr_last;
  logic [BC_W-1:0]       burst_cnt;
  logic [DATA_WIDTH-1:0] q_word [NUM_Q];
  logic                  slot_free;
  logic                  grant_empty;
  logic                  pop;
  logic                  pick_found;
  logic [QID_W-1:0]      pick_idx;
  logic [QID_W-1:0]      cand;

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      q_word[i] = q_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign slot_free   = !out_valid || out_ready;
  assign grant_empty = q_empty[grant_id];
  assign pop         = (state == S_GRANT) && slot_free && !grant_empty;
  assign busy        = (state == S_GRANT);

  // Scan from farthest to nearest so the queue closest after rr_last wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_Q; k >= 1; k--) begin
      cand = QID_W'((int'(rr_last) + k) % NUM_Q);
      if (!q_empty[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    q_re_en = '0;
    if (pop) begin
      q_re_en[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_last   <= QID_W'(NUM_Q - 1);
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && pick_found) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (grant_empty) begin
            rr_last <= grant_id;
            state   <= S_IDLE;
          end else if (pop) begin
            burst_cnt <= burst_cnt + BC_W'(1);
            if (burst_cnt == BURST_LAST) begin
              rr_last <= grant_id;
              state   <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A pop and a downstream handshake in the same cycle simply replace the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= q_word[grant_id];
      out_src   <= grant_id;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
